// File: rtl/mips_ctrl.sv
// Multi-cycle decode/control FSM for a small MIPS subset. It steps each fetched instruction
// through DECODE/EXEC/MEM/WB/PCUPD and returns the PC-update controls to the fetch unit.
module mips_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  input  logic [31:0]      pc,
  input  logic             zero,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [31:0]      imm_ext,
  output logic [1:0]       alu_op,
  output logic             alu_src_imm,
  output logic             reg_dst_rd,
  output logic             mem_to_reg,
  output logic             mem_re,
  output logic             mem_we,
  output logic             reg_we,
  output logic             pc_en,
  output logic             pc_w,
  output logic             pc_a,
  output logic             b_succ,
  output logic [31:0]      wd,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] ill_cnt
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StPcUpd  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      ir_q;
  logic [3:0]       pc_hi_q;
  logic             b_succ_q, b_succ_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  // Only the top nibble of the PC feeds jump-target formation.
  logic unused_pc;
  assign unused_pc = ^pc[27:0];

  logic [5:0] op;
  logic [5:0] funct;
  logic is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_legal;

  assign op    = ir_q[31:26];
  assign funct = ir_q[5:0];

  assign is_addu  = (op == 6'h00) && (funct == 6'h21);
  assign is_subu  = (op == 6'h00) && (funct == 6'h23);
  assign is_ori   = (op == 6'h0D);
  assign is_lui   = (op == 6'h0F);
  assign is_lw    = (op == 6'h23);
  assign is_sw    = (op == 6'h2B);
  assign is_beq   = (op == 6'h04);
  assign is_j     = (op == 6'h02);
  assign is_legal = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq | is_j;

  // Decode outputs come straight from ir, which only changes in IDLE.
  assign rs = ir_q[25:21];
  assign rt = ir_q[20:16];
  assign rd = ir_q[15:11];
  assign imm_ext = (is_ori || is_lui) ? {16'h0000, ir_q[15:0]} : {{16{ir_q[15]}}, ir_q[15:0]};

  assign alu_src_imm = is_ori | is_lui | is_lw | is_sw;
  assign reg_dst_rd  = is_addu | is_subu;
  assign mem_to_reg  = is_lw;

  always_comb begin
    alu_op = 2'd0;
    if (is_subu || is_beq) begin
      alu_op = 2'd1;
    end else if (is_ori) begin
      alu_op = 2'd2;
    end else if (is_lui) begin
      alu_op = 2'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    b_succ_d  = b_succ_q;
    retired_d = retired_q;
    ill_cnt_d = ill_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (instr_valid) state_d = StDecode;
      end
      StDecode: begin
        b_succ_d = 1'b0;
        if (!is_legal) ill_cnt_d = ill_cnt_q + CNT_W'(1);
        state_d = (is_j || !is_legal) ? StPcUpd : StExec;
      end
      StExec: begin
        b_succ_d = zero & is_beq;
        if (is_lw || is_sw) begin
          state_d = StMem;
        end else if (is_beq) begin
          state_d = StPcUpd;
        end else begin
          state_d = StWb;
        end
      end
      StMem: state_d = is_lw ? StWb : StPcUpd;
      StWb: state_d = StPcUpd;
      StPcUpd: begin
        if (is_legal) retired_d = retired_q + CNT_W'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      ir_q      <= 32'h0;
      pc_hi_q   <= 4'h0;
      b_succ_q  <= 1'b0;
      retired_q <= '0;
      ill_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      b_succ_q  <= b_succ_d;
      retired_q <= retired_d;
      ill_cnt_q <= ill_cnt_d;
      if (state_q == StIdle && instr_valid) begin
        ir_q    <= instr;
        pc_hi_q <= pc[31:28];
      end
    end
  end

  assign mem_re  = (state_q == StMem) && is_lw;
  assign mem_we  = (state_q == StMem) && is_sw;
  assign reg_we  = (state_q == StWb);
  assign pc_en   = (state_q == StPcUpd);
  assign illegal = (state_q == StDecode) && !is_legal;

  // PC controls are only meaningful alongside pc_en; zero otherwise means PC+4.
  assign pc_w   = pc_en && is_j;
  assign pc_a   = pc_en && is_beq;
  assign b_succ = b_succ_q;

  always_comb begin
    wd = 32'h0;
    if (pc_en && is_j) begin
      wd = {pc_hi_q, ir_q[25:0], 2'b00};
    end else if (pc_en && is_beq) begin
      wd = imm_ext;
    end
  end

  assign retired = retired_q;
  assign ill_cnt = ill_cnt_q;

endmodule

// File: tb/tb_mips_ctrl.sv
// Self-checking bench for mips_ctrl: directed vector table, randomized instructions against an
// instruction-level reference model, and an asynchronous reset in the middle of a lw.
module tb_mips_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        instr_valid = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        zero = 1'b0;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_ext, wd;
  logic [1:0]  alu_op;
  logic        alu_src_imm, reg_dst_rd, mem_to_reg, mem_re, mem_we, reg_we;
  logic        pc_en, pc_w, pc_a, b_succ, illegal;
  logic [15:0] retired, ill_cnt;

  mips_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .pc(pc), .zero(zero),
    .rs(rs), .rt(rt), .rd(rd), .imm_ext(imm_ext), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .reg_dst_rd(reg_dst_rd), .mem_to_reg(mem_to_reg), .mem_re(mem_re), .mem_we(mem_we),
    .reg_we(reg_we), .pc_en(pc_en), .pc_w(pc_w), .pc_a(pc_a), .b_succ(b_succ), .wd(wd),
    .illegal(illegal), .retired(retired), .ill_cnt(ill_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int mdl_ret = 0;
  int mdl_ill = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: instruction kind 0..8 = addu subu ori lui lw sw beq j illegal.
  function automatic int kind_of(input logic [31:0] w);
    logic [5:0] o;
    o = w[31:26];
    if (o == 6'h00 && w[5:0] == 6'h21) return 0;
    if (o == 6'h00 && w[5:0] == 6'h23) return 1;
    if (o == 6'h0D) return 2;
    if (o == 6'h0F) return 3;
    if (o == 6'h23) return 4;
    if (o == 6'h2B) return 5;
    if (o == 6'h04) return 6;
    if (o == 6'h02) return 7;
    return 8;
  endfunction

  // Observations from one instruction.
  int          m_lat;
  logic [15:0] m_re, m_we, m_rwe, m_ill;
  logic [31:0] m_wd, m_imm;
  logic        m_pcw, m_pca, m_bs, m_src, m_dst, m_m2r;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [1:0]  m_aluop;

  task automatic run(input logic [31:0] i, input logic [31:0] p, input logic z);
    @(negedge clk);
    instr = i; pc = p; zero = z; instr_valid = 1'b1;
    @(negedge clk);
    m_lat = 0; m_re = '0; m_we = '0; m_rwe = '0; m_ill = '0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      if (mem_re)  m_re[k] = 1'b1;
      if (mem_we)  m_we[k] = 1'b1;
      if (reg_we)  m_rwe[k] = 1'b1;
      if (illegal) m_ill[k] = 1'b1;
      if (pc_en) begin
        m_lat = k;
        m_wd = wd; m_pcw = pc_w; m_pca = pc_a; m_bs = b_succ;
        m_rs = rs; m_rt = rt; m_rd = rd; m_imm = imm_ext; m_aluop = alu_op;
        m_src = alu_src_imm; m_dst = reg_dst_rd; m_m2r = mem_to_reg;
        break;
      end
      // Garbage on the fetch side outside IDLE must be ignored.
      instr = $urandom;
      instr_valid = 1'($urandom_range(0, 1));
    end
    instr_valid = 1'b0;
    if (m_lat == 0) chk("pc_en_timeout", 32'd0, 32'd1);
    if (kind_of(i) == 8) mdl_ill++;
    else mdl_ret++;
    @(posedge clk);
    #1;
    chk("retired", 32'(retired), 32'(mdl_ret & 16'hFFFF));
    chk("ill_cnt", 32'(ill_cnt), 32'(mdl_ill & 16'hFFFF));
  endtask

  typedef struct {
    logic [31:0] i;
    logic [31:0] p;
    logic        z;
    int          lat;
    logic        pcw;
    logic        pca;
    logic        bs;
    logic [31:0] wd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [31:0] gen(input int k);
    logic [31:0] w;
    w = $urandom;
    case (k)
      0: begin w[31:26] = 6'h00; w[5:0] = 6'h21; end
      1: begin w[31:26] = 6'h00; w[5:0] = 6'h23; end
      2: w[31:26] = 6'h0D;
      3: w[31:26] = 6'h0F;
      4: w[31:26] = 6'h23;
      5: w[31:26] = 6'h2B;
      6: w[31:26] = 6'h04;
      7: w[31:26] = 6'h02;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    int lat_tab[9] = '{4, 4, 4, 4, 5, 4, 3, 2, 2};
    int aop_tab[7] = '{0, 1, 2, 3, 0, 0, 1};
    logic        bad;

    tbl[0] = '{32'h00228021, 32'h00001000, 1'b0, 4, 1'b0, 1'b0, 1'b0, 32'h0,
               5'd1, 5'd2, 5'd16, 32'hFFFF8021};
    tbl[1] = '{32'h8C330002, 32'h00001004, 1'b0, 5, 1'b0, 1'b0, 1'b0, 32'h0,
               5'd1, 5'd19, 5'd0, 32'h00000002};
    tbl[2] = '{32'h10210004, 32'h00001008, 1'b1, 3, 1'b0, 1'b1, 1'b1, 32'h00000004,
               5'd1, 5'd1, 5'd0, 32'h00000004};
    tbl[3] = '{32'h1042FFE0, 32'h0000100C, 1'b0, 3, 1'b0, 1'b1, 1'b0, 32'hFFFFFFE0,
               5'd2, 5'd2, 5'd31, 32'hFFFFFFE0};
    tbl[4] = '{32'h08000010, 32'h40000000, 1'b0, 2, 1'b1, 1'b0, 1'b0, 32'h40000040,
               5'd0, 5'd0, 5'd0, 32'h00000010};
    tbl[5] = '{32'hFFFFFFFF, 32'h00002000, 1'b1, 2, 1'b0, 1'b0, 1'b0, 32'h0,
               5'd31, 5'd31, 5'd31, 32'hFFFFFFFF};
    tbl[6] = '{32'h3421ABCD, 32'h00002004, 1'b0, 4, 1'b0, 1'b0, 1'b0, 32'h0,
               5'd1, 5'd1, 5'd21, 32'h0000ABCD};
    tbl[7] = '{32'h3C0F8000, 32'h00002008, 1'b0, 4, 1'b0, 1'b0, 1'b0, 32'h0,
               5'd0, 5'd15, 5'd16, 32'h00008000};
    tbl[8] = '{32'hAC45FFFC, 32'h0000200C, 1'b1, 4, 1'b0, 1'b0, 1'b0, 32'h0,
               5'd2, 5'd5, 5'd31, 32'hFFFFFFFC};
    tbl[9] = '{32'h00A41823, 32'hF0000010, 1'b1, 4, 1'b0, 1'b0, 1'b0, 32'h0,
               5'd5, 5'd4, 5'd3, 32'h00001823};

    // Reset state.
    #12;
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_reg_we", 32'(reg_we), 32'd0);
    chk("rst_wd", wd, 32'h0);
    chk("rst_b_succ", 32'(b_succ), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_ill_cnt", 32'(ill_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed vector table.
    for (int n = 0; n < 10; n++) begin
      run(tbl[n].i, tbl[n].p, tbl[n].z);
      chk($sformatf("v%0d_lat", n), 32'(m_lat), 32'(tbl[n].lat));
      chk($sformatf("v%0d_pc_w", n), 32'(m_pcw), 32'(tbl[n].pcw));
      chk($sformatf("v%0d_pc_a", n), 32'(m_pca), 32'(tbl[n].pca));
      chk($sformatf("v%0d_b_succ", n), 32'(m_bs), 32'(tbl[n].bs));
      chk($sformatf("v%0d_wd", n), m_wd, tbl[n].wd);
      chk($sformatf("v%0d_rs", n), 32'(m_rs), 32'(tbl[n].rs));
      chk($sformatf("v%0d_rt", n), 32'(m_rt), 32'(tbl[n].rt));
      chk($sformatf("v%0d_rd", n), 32'(m_rd), 32'(tbl[n].rd));
      chk($sformatf("v%0d_imm", n), m_imm, tbl[n].imm);
    end

    // Randomized instructions against the reference model.
    for (int n = 0; n < 80; n++) begin
      logic [31:0] w, p, ewd;
      logic        z;
      int          k;
      w = gen($urandom_range(0, 8));
      p = $urandom;
      z = 1'($urandom_range(0, 1));
      k = kind_of(w);
      run(w, p, z);
      ewd = 32'h0;
      if (k == 7) ewd = (p & 32'hF0000000) | ((w & 32'h03FFFFFF) << 2);
      if (k == 6) ewd = 32'($signed(w[15:0]));
      chk($sformatf("r%0d_lat", n), 32'(m_lat), 32'(lat_tab[k]));
      chk($sformatf("r%0d_pc_w", n), 32'(m_pcw), 32'(k == 7));
      chk($sformatf("r%0d_pc_a", n), 32'(m_pca), 32'(k == 6));
      chk($sformatf("r%0d_b_succ", n), 32'(m_bs), 32'(k == 6 && z));
      chk($sformatf("r%0d_wd", n), m_wd, ewd);
      chk($sformatf("r%0d_rs", n), 32'(m_rs), 32'(w[25:21]));
      chk($sformatf("r%0d_rt", n), 32'(m_rt), 32'(w[20:16]));
      chk($sformatf("r%0d_rd", n), 32'(m_rd), 32'(w[15:11]));
      chk($sformatf("r%0d_imm", n), m_imm,
          (k == 2 || k == 3) ? 32'(w[15:0]) : 32'($signed(w[15:0])));
      chk($sformatf("r%0d_mem_re", n), 32'(m_re), (k == 4) ? 32'h8 : 32'h0);
      chk($sformatf("r%0d_mem_we", n), 32'(m_we), (k == 5) ? 32'h8 : 32'h0);
      chk($sformatf("r%0d_reg_we", n), 32'(m_rwe),
          (k <= 3) ? 32'h8 : (k == 4) ? 32'h10 : 32'h0);
      chk($sformatf("r%0d_illegal", n), 32'(m_ill), (k == 8) ? 32'h2 : 32'h0);
      if (k <= 6) begin
        chk($sformatf("r%0d_alu_op", n), 32'(m_aluop), 32'(aop_tab[k]));
        chk($sformatf("r%0d_src_imm", n), 32'(m_src), 32'(k == 2 || k == 3 || k == 4 || k == 5));
        chk($sformatf("r%0d_dst_rd", n), 32'(m_dst), 32'(k == 0 || k == 1));
        chk($sformatf("r%0d_mem_to_reg", n), 32'(m_m2r), 32'(k == 4));
      end
    end

    // Asynchronous reset while a lw is in MEM.
    @(negedge clk);
    instr = 32'h8C330002; pc = 32'h0; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_mem_re_before", 32'(mem_re), 32'd1);
    #1;
    reset = 1'b0;
    mdl_ret = 0;
    mdl_ill = 0;
    #1;
    chk("mid_mem_re_after", 32'(mem_re), 32'd0);
    chk("mid_retired", 32'(retired), 32'd0);
    chk("mid_ill_cnt", 32'(ill_cnt), 32'd0);
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (reg_we || pc_en || mem_re) bad = 1'b1;
    end
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (reg_we || pc_en || mem_re) bad = 1'b1;
    end
    chk("mid_no_stray_strobe", 32'(bad), 32'd0);
    run(tbl[0].i, tbl[0].p, tbl[0].z);
    chk("post_rst_lat", 32'(m_lat), 32'd4);
    chk("post_rst_rd", 32'(m_rd), 32'd16);
    chk("post_rst_reg_we", 32'(m_rwe), 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
